// File: rtl/obi_wb_arbiter_bridge_if.sv
// Bundle of the OBI-style port signals and the Wishbone master port.
// slave = bridge side, master = cores plus bus side.
interface obi_wb_arbiter_bridge_if #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int SEL_W = DATA_WIDTH / 8;

  logic [NUM_PORTS-1:0]            req_i;
  logic [NUM_PORTS-1:0]            gnt_o;
  logic [NUM_PORTS-1:0]            we_i;
  logic [NUM_PORTS*SEL_W-1:0]      be_i;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] addr_i;
  logic [NUM_PORTS*DATA_WIDTH-1:0] wdata_i;
  logic [NUM_PORTS-1:0]            rvalid_o;
  logic [NUM_PORTS-1:0]            rready_i;
  logic [NUM_PORTS*DATA_WIDTH-1:0] rdata_o;
  logic [NUM_PORTS-1:0]            err_o;
  logic                            wb_cyc_o;
  logic                            wb_stb_o;
  logic                            wb_we_o;
  logic [ADDR_WIDTH-1:0]           wb_adr_o;
  logic [SEL_W-1:0]                wb_sel_o;
  logic [DATA_WIDTH-1:0]           wb_dat_o;
  logic [DATA_WIDTH-1:0]           wb_dat_i;
  logic                            wb_ack_i;
  logic                            wb_err_i;
  logic                            busy_o;

  modport slave (
    input  req_i, we_i, be_i, addr_i, wdata_i, rready_i,
    input  wb_dat_i, wb_ack_i, wb_err_i,
    output gnt_o, rvalid_o, rdata_o, err_o,
    output wb_cyc_o, wb_stb_o, wb_we_o,
    output wb_adr_o, wb_sel_o, wb_dat_o, busy_o
  );

  modport master (
    output req_i, we_i, be_i, addr_i, wdata_i, rready_i,
    output wb_dat_i, wb_ack_i, wb_err_i,
    input  gnt_o, rvalid_o, rdata_o, err_o,
    input  wb_cyc_o, wb_stb_o, wb_we_o,
    input  wb_adr_o, wb_sel_o, wb_dat_o, busy_o
  );
endinterface

// File: rtl/obi_wb_arbiter_bridge.sv
// Round-robin bridge from NUM_PORTS OBI-style masters to one Wishbone master.
// Optional bus watchdog: define BRIDGE_TIMEOUT_EN.
module obi_wb_arbiter_bridge #(
  parameter int NUM_PORTS      = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int RSP_DEPTH      = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic                  clk,
  input logic                  rst_n,
  obi_wb_arbiter_bridge_if.slave bus
);
  localparam int SEL_W = DATA_WIDTH / 8;
  localparam int PW    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int FW    = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CW    = $clog2(RSP_DEPTH + 1);
  localparam int EW    = DATA_WIDTH + 1;

  typedef enum logic {S_IDLE, S_BUS} state_t;

  state_t                r_state;
  logic [PW-1:0]         r_ptr;
  logic [PW-1:0]         r_port;
  logic                  r_we;
  logic [SEL_W-1:0]      r_sel;
  logic [ADDR_WIDTH-1:0] r_adr;
  logic [DATA_WIDTH-1:0] r_dat;

  logic [EW-1:0] r_mem [NUM_PORTS][RSP_DEPTH];
  logic [FW-1:0] r_wp  [NUM_PORTS];
  logic [FW-1:0] r_rp  [NUM_PORTS];
  logic [CW-1:0] r_cnt [NUM_PORTS];

  logic [NUM_PORTS-1:0] w_elig;
  logic [NUM_PORTS-1:0] w_gnt;
  logic [NUM_PORTS-1:0] w_push;
  logic [NUM_PORTS-1:0] w_pop;
  logic [NUM_PORTS-1:0] w_rvalid;
  logic [PW-1:0]        w_win;
  logic [PW-1:0]        w_idx;
  logic                 w_found;
  logic                 w_tmo;
  logic                 w_term;
  logic                 w_err;
  logic [EW-1:0]        w_rsp;

  function automatic logic [FW-1:0] f_inc(input logic [FW-1:0] v);
    return (v == FW'(RSP_DEPTH - 1)) ? '0 : v + 1'b1;
  endfunction

`ifdef BRIDGE_TIMEOUT_EN
  localparam int TW0 = $clog2(TIMEOUT_CYCLES + 1);
  localparam int TW  = (TW0 < 8) ? 8 : ((TW0 > 32) ? 32 : TW0);

  logic [TW-1:0] r_tmo;

  assign w_tmo = (r_state == S_BUS) &&
                 (r_tmo == TW'(TIMEOUT_CYCLES - 1));

  // Watchdog: counts BUS cycles, held at zero in IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tmo <= '0;
    end else if (r_state == S_IDLE) begin
      r_tmo <= '0;
    end else begin
      r_tmo <= r_tmo + 1'b1;
    end
  end
`else
  localparam int unused_tmo = TIMEOUT_CYCLES;

  assign w_tmo = 1'b0;
`endif

  // Termination and the response word pushed for it.
  always_comb begin
    w_term = bus.wb_ack_i | bus.wb_err_i | w_tmo;
    w_err  = bus.wb_err_i | (w_tmo & ~bus.wb_ack_i);
    w_rsp  = {w_err, (r_we || w_err) ? '0 : bus.wb_dat_i};
  end

  // Per-port eligibility, push, pop and valid.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      w_elig[p]   = bus.req_i[p] && (r_cnt[p] < CW'(RSP_DEPTH));
      w_rvalid[p] = (r_cnt[p] != '0);
      w_pop[p]    = w_rvalid[p] && bus.rready_i[p];
      w_push[p]   = (r_state == S_BUS) && w_term &&
                    (r_port == PW'(p));
    end
  end

  // Round-robin pick: first eligible port after the pointer.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      w_idx = PW'((int'(r_ptr) + i) % NUM_PORTS);
      if (!w_found && w_elig[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  // One-hot grant, only offered in IDLE.
  always_comb begin
    w_gnt = '0;
    if (r_state == S_IDLE && w_found) begin
      w_gnt[w_win] = 1'b1;
    end
  end

  // Arbitration / bus FSM with latched request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ptr   <= PW'(NUM_PORTS - 1);
      r_port  <= '0;
      r_we    <= 1'b0;
      r_sel   <= '0;
      r_adr   <= '0;
      r_dat   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state <= S_BUS;
            r_ptr   <= w_win;
            r_port  <= w_win;
            r_we    <= bus.we_i[w_win];
            r_sel   <= bus.be_i[w_win*SEL_W +: SEL_W];
            r_adr   <= bus.addr_i[w_win*ADDR_WIDTH +: ADDR_WIDTH];
            r_dat   <= bus.wdata_i[w_win*DATA_WIDTH +: DATA_WIDTH];
          end
        end
        S_BUS: begin
          if (w_term) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Response FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        r_wp[p]  <= '0;
        r_rp[p]  <= '0;
        r_cnt[p] <= '0;
      end
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (w_push[p]) r_wp[p] <= f_inc(r_wp[p]);
        if (w_pop[p])  r_rp[p] <= f_inc(r_rp[p]);
        if (w_push[p] && !w_pop[p]) begin
          r_cnt[p] <= r_cnt[p] + 1'b1;
        end else if (!w_push[p] && w_pop[p]) begin
          r_cnt[p] <= r_cnt[p] - 1'b1;
        end
      end
    end
  end

  // Response FIFO storage; contents are masked while empty.
  always_ff @(posedge clk) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (w_push[p]) r_mem[p][r_wp[p]] <= w_rsp;
    end
  end

  // Head-of-FIFO response outputs, zero when empty.
  always_comb begin
    bus.rdata_o = '0;
    bus.err_o   = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (w_rvalid[p]) begin
        bus.rdata_o[p*DATA_WIDTH +: DATA_WIDTH] =
          r_mem[p][r_rp[p]][DATA_WIDTH-1:0];
        bus.err_o[p] = r_mem[p][r_rp[p]][DATA_WIDTH];
      end
    end
  end

  assign bus.gnt_o    = w_gnt;
  assign bus.rvalid_o = w_rvalid;
  assign bus.wb_cyc_o = (r_state == S_BUS);
  assign bus.wb_stb_o = (r_state == S_BUS);
  assign bus.busy_o   = (r_state == S_BUS);
  assign bus.wb_we_o  = r_we;
  assign bus.wb_adr_o = r_adr;
  assign bus.wb_sel_o = r_sel;
  assign bus.wb_dat_o = r_dat;

endmodule

// File: tb/tb_obi_wb_arbiter_bridge.sv
// Directed bench for obi_wb_arbiter_bridge (2 ports, depth 2).
// Inputs change on the falling edge; outputs sampled 1ns later.
module tb_obi_wb_arbiter_bridge;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;

  obi_wb_arbiter_bridge_if #(
    .NUM_PORTS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32)
  ) bus ();

  obi_wb_arbiter_bridge #(
    .NUM_PORTS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32),
    .RSP_DEPTH(2), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.req_i = '0; bus.we_i = '0; bus.be_i = '0;
    bus.addr_i = '0; bus.wdata_i = '0; bus.rready_i = '1;
    bus.wb_dat_i = '0; bus.wb_ack_i = 1'b0; bus.wb_err_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if ({bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.busy_o} !== 4'b0) begin errors++; $display("FAIL rst_ctl got %b want 0000", {bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.busy_o}); end
    checks++; if (bus.wb_adr_o !== 32'h0 || bus.wb_sel_o !== 4'h0 || bus.wb_dat_o !== 32'h0) begin errors++; $display("FAIL rst_wb got %h %h %h want 0", bus.wb_adr_o, bus.wb_sel_o, bus.wb_dat_o); end
    checks++; if (bus.gnt_o !== 2'b00 || bus.rvalid_o !== 2'b00) begin errors++; $display("FAIL rst_gnt_rvalid got %b %b want 00 00", bus.gnt_o, bus.rvalid_o); end
    checks++; if (bus.rdata_o !== 64'h0 || bus.err_o !== 2'b00) begin errors++; $display("FAIL rst_rsp got %h %b want 0", bus.rdata_o, bus.err_o); end
  endtask

  task automatic test_read();
    do_reset();
    bus.req_i = 2'b01; bus.addr_i[31:0] = 32'h100; bus.be_i[3:0] = 4'hF;
    #1;
    checks++; if (bus.gnt_o !== 2'b01) begin errors++; $display("FAIL read_gnt got %b want 01", bus.gnt_o); end
    @(negedge clk); bus.req_i = '0; #1;
    checks++; if (bus.wb_cyc_o !== 1'b1 || bus.wb_stb_o !== 1'b1 || bus.wb_we_o !== 1'b0) begin errors++; $display("FAIL read_cyc1 got %b%b%b want 110", bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o); end
    checks++; if (bus.wb_adr_o !== 32'h100) begin errors++; $display("FAIL read_adr got %h want 00000100", bus.wb_adr_o); end
    @(negedge clk); bus.wb_ack_i = 1'b1; bus.wb_dat_i = 32'hDEADBEEF; #1;
    checks++; if (bus.wb_cyc_o !== 1'b1 || bus.rvalid_o !== 2'b00) begin errors++; $display("FAIL read_cyc2 got %b %b want 1 00", bus.wb_cyc_o, bus.rvalid_o); end
    @(negedge clk); bus.wb_ack_i = 1'b0; bus.wb_dat_i = '0; #1;
    checks++; if (bus.rvalid_o !== 2'b01 || bus.wb_cyc_o !== 1'b0) begin errors++; $display("FAIL read_rvalid got %b cyc %b want 01 0", bus.rvalid_o, bus.wb_cyc_o); end
    checks++; if (bus.rdata_o[31:0] !== 32'hDEADBEEF || bus.err_o !== 2'b00) begin errors++; $display("FAIL read_data got %h %b want deadbeef 00", bus.rdata_o[31:0], bus.err_o); end
    @(negedge clk); #1;
    checks++; if (bus.rvalid_o !== 2'b00) begin errors++; $display("FAIL read_pop got %b want 00", bus.rvalid_o); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_g [8];
    exp_g[0] = 2'b01; exp_g[1] = 2'b00; exp_g[2] = 2'b10; exp_g[3] = 2'b00;
    exp_g[4] = 2'b01; exp_g[5] = 2'b00; exp_g[6] = 2'b10; exp_g[7] = 2'b00;
    do_reset();
    bus.req_i = 2'b11; bus.wb_ack_i = 1'b1; bus.wb_dat_i = 32'h55;
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++; if (bus.gnt_o !== exp_g[i]) begin errors++; $display("FAIL b2b_gnt[%0d] got %b want %b", i, bus.gnt_o, exp_g[i]); end
      @(negedge clk);
    end
    bus.req_i = '0; bus.wb_ack_i = 1'b0;
  endtask

  task automatic test_write();
    do_reset();
    bus.req_i = 2'b10; bus.we_i = 2'b10; bus.be_i[7:4] = 4'b0011;
    bus.addr_i[63:32] = 32'h40; bus.wdata_i[63:32] = 32'h1234;
    #1;
    checks++; if (bus.gnt_o !== 2'b10) begin errors++; $display("FAIL wr_gnt got %b want 10", bus.gnt_o); end
    @(negedge clk);
    bus.req_i = '0; bus.wb_ack_i = 1'b1; bus.wb_dat_i = 32'hFFFFFFFF; #1;
    checks++; if (bus.wb_cyc_o !== 1'b1 || bus.wb_we_o !== 1'b1 || bus.wb_sel_o !== 4'b0011) begin errors++; $display("FAIL wr_ctl got cyc %b we %b sel %b want 1 1 0011", bus.wb_cyc_o, bus.wb_we_o, bus.wb_sel_o); end
    checks++; if (bus.wb_dat_o !== 32'h1234 || bus.wb_adr_o !== 32'h40) begin errors++; $display("FAIL wr_bus got dat %h adr %h want 00001234 00000040", bus.wb_dat_o, bus.wb_adr_o); end
    @(negedge clk); bus.wb_ack_i = 1'b0; bus.we_i = '0; #1;
    checks++; if (bus.rvalid_o !== 2'b10 || bus.rdata_o[63:32] !== 32'h0 || bus.err_o !== 2'b00) begin errors++; $display("FAIL wr_rsp got %b %h %b want 10 0 00", bus.rvalid_o, bus.rdata_o[63:32], bus.err_o); end
  endtask

  task automatic test_fifo_full();
    do_reset();
    bus.rready_i = 2'b10; bus.req_i = 2'b01; bus.addr_i[31:0] = 32'h200;
    #1;
    checks++; if (bus.gnt_o !== 2'b01) begin errors++; $display("FAIL ff_gnt1 got %b want 01", bus.gnt_o); end
    @(negedge clk); bus.wb_ack_i = 1'b1; bus.wb_dat_i = 32'h11;
    @(negedge clk); bus.wb_ack_i = 1'b0; #1;
    checks++; if (bus.gnt_o !== 2'b01) begin errors++; $display("FAIL ff_gnt2 got %b want 01", bus.gnt_o); end
    @(negedge clk); bus.wb_ack_i = 1'b1; bus.wb_dat_i = 32'h22;
    @(negedge clk); bus.wb_ack_i = 1'b0; #1;
    checks++; if (bus.gnt_o !== 2'b00) begin errors++; $display("FAIL ff_held got %b want 00", bus.gnt_o); end
    checks++; if (bus.rvalid_o[0] !== 1'b1 || bus.rdata_o[31:0] !== 32'h11) begin errors++; $display("FAIL ff_head1 got %b %h want 1 00000011", bus.rvalid_o[0], bus.rdata_o[31:0]); end
    @(negedge clk); #1;
    checks++; if (bus.gnt_o !== 2'b00) begin errors++; $display("FAIL ff_held2 got %b want 00", bus.gnt_o); end
    @(negedge clk); bus.rready_i = 2'b11; #1;
    checks++; if (bus.gnt_o !== 2'b00) begin errors++; $display("FAIL ff_held3 got %b want 00", bus.gnt_o); end
    @(negedge clk); bus.rready_i = 2'b10; #1;
    checks++; if (bus.gnt_o !== 2'b01) begin errors++; $display("FAIL ff_gnt3 got %b want 01", bus.gnt_o); end
    checks++; if (bus.rdata_o[31:0] !== 32'h22) begin errors++; $display("FAIL ff_head2 got %h want 00000022", bus.rdata_o[31:0]); end
    @(negedge clk); bus.req_i = '0; bus.wb_ack_i = 1'b1; bus.wb_dat_i = 32'h33; #1;
    checks++; if (bus.wb_cyc_o !== 1'b1) begin errors++; $display("FAIL ff_cyc3 got %b want 1", bus.wb_cyc_o); end
    @(negedge clk); bus.wb_ack_i = 1'b0; #1;
    checks++; if (bus.rvalid_o[0] !== 1'b1 || bus.rdata_o[31:0] !== 32'h22) begin errors++; $display("FAIL ff_head3 got %b %h want 1 00000022", bus.rvalid_o[0], bus.rdata_o[31:0]); end
  endtask

  task automatic test_err();
    do_reset();
    bus.req_i = 2'b01; bus.addr_i[31:0] = 32'h300;
    #1;
    checks++; if (bus.gnt_o !== 2'b01) begin errors++; $display("FAIL err_gnt got %b want 01", bus.gnt_o); end
    @(negedge clk);
    bus.req_i = '0; bus.wb_ack_i = 1'b1; bus.wb_err_i = 1'b1; bus.wb_dat_i = 32'hCAFEF00D;
    @(negedge clk); bus.wb_ack_i = 1'b0; bus.wb_err_i = 1'b0; #1;
    checks++; if (bus.rvalid_o !== 2'b01 || bus.err_o !== 2'b01) begin errors++; $display("FAIL err_flag got %b %b want 01 01", bus.rvalid_o, bus.err_o); end
    checks++; if (bus.rdata_o[31:0] !== 32'h0) begin errors++; $display("FAIL err_data got %h want 00000000", bus.rdata_o[31:0]); end
  endtask

  task automatic test_reset_mid_bus();
    do_reset();
    bus.rready_i = 2'b00; bus.req_i = 2'b10;
    #1;
    checks++; if (bus.gnt_o !== 2'b10) begin errors++; $display("FAIL mrst_gnt1 got %b want 10", bus.gnt_o); end
    @(negedge clk); bus.req_i = '0; bus.wb_ack_i = 1'b1; bus.wb_dat_i = 32'h77;
    @(negedge clk); bus.wb_ack_i = 1'b0; bus.req_i = 2'b01; #1;
    checks++; if (bus.rvalid_o !== 2'b10 || bus.gnt_o !== 2'b01) begin errors++; $display("FAIL mrst_pre got %b %b want 10 01", bus.rvalid_o, bus.gnt_o); end
    @(negedge clk); bus.req_i = '0; rst_n = 1'b0; #1;
    checks++; if (bus.wb_cyc_o !== 1'b1) begin errors++; $display("FAIL mrst_bus got %b want 1", bus.wb_cyc_o); end
    @(negedge clk); rst_n = 1'b1; bus.req_i = 2'b11; #1;
    checks++; if (bus.wb_cyc_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.rvalid_o !== 2'b00) begin errors++; $display("FAIL mrst_post got cyc %b busy %b rvalid %b want 0 0 00", bus.wb_cyc_o, bus.busy_o, bus.rvalid_o); end
    checks++; if (bus.gnt_o !== 2'b01) begin errors++; $display("FAIL mrst_gnt got %b want 01", bus.gnt_o); end
    @(negedge clk); bus.req_i = '0;
  endtask

`ifdef BRIDGE_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    bus.req_i = 2'b01;
    #1;
    checks++; if (bus.gnt_o !== 2'b01) begin errors++; $display("FAIL tmo_gnt got %b want 01", bus.gnt_o); end
    @(negedge clk); bus.req_i = '0;
    for (int k = 1; k <= 16; k++) begin
      #1;
      checks++; if (bus.wb_cyc_o !== 1'b1) begin errors++; $display("FAIL tmo_cyc[%0d] got %b want 1", k, bus.wb_cyc_o); end
      @(negedge clk);
    end
    #1;
    checks++; if (bus.wb_cyc_o !== 1'b0) begin errors++; $display("FAIL tmo_drop got %b want 0", bus.wb_cyc_o); end
    checks++; if (bus.rvalid_o !== 2'b01 || bus.err_o !== 2'b01 || bus.rdata_o[31:0] !== 32'h0) begin errors++; $display("FAIL tmo_rsp got %b %b %h want 01 01 0", bus.rvalid_o, bus.err_o, bus.rdata_o[31:0]); end
  endtask
`endif

  initial begin
    test_reset();
    test_read();
    test_back_to_back();
    test_write();
    test_fifo_full();
    test_err();
    test_reset_mid_bus();
`ifdef BRIDGE_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
